// File: rtl/dafx_mixer_if.sv
// Output stream of the DAFX mixer: a mixed sample offered with valid/ready.
// The mixer drives it through the master modport; the DAC/codec stage uses slave.
interface dafx_mixer_if #(
    parameter int AUDIO_WIDTH_P = 24
) ();
    logic                     mix_valid;
    logic                     mix_ready;
    logic [AUDIO_WIDTH_P-1:0] mix_data;

    modport master (output mix_valid, output mix_data, input mix_ready);
    modport slave  (input mix_valid, input mix_data, output mix_ready);
endinterface

// File: rtl/dafx_mixer.sv
// DAFX sample-rate mixer: sampling tick, sequential gain-weighted MAC with saturation.
// Define DAFX_MIXER_CLIP_COUNT_EN to add the sr_clip_cnt clip counter port.
module dafx_mixer #(
    parameter int AUDIO_WIDTH_P    = 24,
    parameter int GAIN_WIDTH_P     = 24,
    parameter int Q_BITS_P         = 11,
    parameter int NR_OF_CHANNELS_P = 3,
    parameter int SAMPLE_PERIOD_P  = 12500
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      cr_mix_enable,
    input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] ch_data,
    input  logic [NR_OF_CHANNELS_P*GAIN_WIDTH_P-1:0]  ch_gain,
    output logic                                      irq_sample,
    dafx_mixer_if.master                              mix,
    output logic [15:0]                               sr_overrun_cnt
`ifdef DAFX_MIXER_CLIP_COUNT_EN
    ,
    output logic [15:0]                               sr_clip_cnt
`endif
);

    localparam int CNT_W  = $clog2(SAMPLE_PERIOD_P);
    localparam int IDX_W  = (NR_OF_CHANNELS_P > 1) ? $clog2(NR_OF_CHANNELS_P) : 1;
    localparam int PROD_W = AUDIO_WIDTH_P + GAIN_WIDTH_P;
    localparam int ACC_W  = PROD_W + $clog2(NR_OF_CHANNELS_P) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD_P - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NR_OF_CHANNELS_P - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-AUDIO_WIDTH_P+1){1'b0}}, {(AUDIO_WIDTH_P-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, SAT, OUT} state_e;

    state_e                                    state_q;
    logic [CNT_W-1:0]                          cnt_q;
    logic [IDX_W-1:0]                          idx_q;
    logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] data_q;
    logic [NR_OF_CHANNELS_P*GAIN_WIDTH_P-1:0]  gain_q;
    logic signed [ACC_W-1:0]                   acc_q;
    logic signed [ACC_W-1:0]                   acc_d;
    logic                                      mix_valid_q;
    logic [AUDIO_WIDTH_P-1:0]                  mix_data_q;
    logic [15:0]                               ovr_q;

    logic signed [AUDIO_WIDTH_P-1:0] cur_data;
    logic signed [GAIN_WIDTH_P-1:0]  cur_gain;
    logic signed [PROD_W-1:0]        prod;
    logic signed [ACC_W-1:0]         mac_term;
    logic                            pos_clip;
    logic                            neg_clip;
    logic [AUDIO_WIDTH_P-1:0]        sat_d;

    // Counter sits at zero while disabled, so re-enabling always starts a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!cr_mix_enable || cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign irq_sample = cr_mix_enable && (cnt_q == CNT_LAST);

    always_comb begin
        cur_data = data_q[idx_q*AUDIO_WIDTH_P +: AUDIO_WIDTH_P];
        cur_gain = gain_q[idx_q*GAIN_WIDTH_P +: GAIN_WIDTH_P];
        prod     = cur_data * cur_gain;
        mac_term = ACC_W'(prod >>> Q_BITS_P);
        acc_d    = acc_q + mac_term;
        pos_clip = acc_q > SAT_MAX;
        neg_clip = acc_q < SAT_MIN;
        if (pos_clip) begin
            sat_d = {1'b0, {(AUDIO_WIDTH_P-1){1'b1}}};
        end else if (neg_clip) begin
            sat_d = {1'b1, {(AUDIO_WIDTH_P-1){1'b0}}};
        end else begin
            sat_d = acc_q[AUDIO_WIDTH_P-1:0];
        end
    end

    // A tick outside IDLE is counted even when it coincides with the OUT handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            data_q      <= '0;
            gain_q      <= '0;
            acc_q       <= '0;
            mix_valid_q <= 1'b0;
            mix_data_q  <= '0;
            ovr_q       <= '0;
        end else begin
            if (irq_sample && state_q != IDLE && ovr_q != '1) begin
                ovr_q <= ovr_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (irq_sample) begin
                        data_q  <= ch_data;
                        gain_q  <= ch_gain;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (idx_q == IDX_LAST) begin
                        state_q <= SAT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                SAT: begin
                    mix_data_q  <= sat_d;
                    mix_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (mix.mix_ready) begin
                        mix_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DAFX_MIXER_CLIP_COUNT_EN
    logic [15:0] clip_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_q <= '0;
        end else if (state_q == SAT && (pos_clip || neg_clip) && clip_q != '1) begin
            clip_q <= clip_q + 1'b1;
        end
    end

    assign sr_clip_cnt = clip_q;
`endif

    assign mix.mix_valid  = mix_valid_q;
    assign mix.mix_data   = mix_data_q;
    assign sr_overrun_cnt = ovr_q;

endmodule
